// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA operand sequencer and its helpers.
package rsa_pkg;

  localparam int unsigned DEF_BITLEN = 512;
  localparam int unsigned DEF_ABITS  = 8;
  localparam int unsigned DEF_DBITS  = 512;

  // Operand block layout inside the bram, in words from the block base.
  localparam int unsigned OFF_X_LO   = 0;
  localparam int unsigned OFF_X_HI   = 1;
  localparam int unsigned OFF_M_LO   = 2;
  localparam int unsigned OFF_M_HI   = 3;
  localparam int unsigned OPER_WORDS = 4;
  localparam int unsigned IDX_W      = $clog2(OPER_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/run_timer.sv
// RUN-phase cycle counter (clear-to-1, saturating), timeout compare and
// rising-edge detector on the mon_exp stop level.
module run_timer #(
  parameter int unsigned CW      = 32,
  parameter int unsigned TIMEOUT = 1 << 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic          i_stop,
  output logic [CW-1:0] o_count_nxt_c,
  output logic          o_timeout_c,
  output logic          o_stop_rise_c
);

  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  logic [CW-1:0] r_count;
  logic          r_stop_q;

  always_comb begin
    o_count_nxt_c = (&r_count) ? r_count : r_count + CW'(1);
  end

  assign o_timeout_c   = i_enable && (o_count_nxt_c >= TO_LIM);
  assign o_stop_rise_c = i_stop && !r_stop_q;

  // stop_q tracks stop in every state so a stale high level never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_stop_q <= 1'b0;
    end else begin
      r_stop_q <= i_stop;
      if (i_clear) begin
        r_count <= CW'(1);
      end else if (i_enable) begin
        r_count <= o_count_nxt_c;
      end
    end
  end

endmodule

// File: rtl/mon_exp_seq.sv
// Job sequencer for mon_exp: loads X_bar/M_bar into the bram operand block,
// pulses start, waits for the stop edge (or timeout) and returns the answer.
module mon_exp_seq
  import rsa_pkg::*;
#(
  parameter int unsigned BITLEN    = DEF_BITLEN,
  parameter int unsigned ABITS     = DEF_ABITS,
  parameter int unsigned DBITS     = DEF_DBITS,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 1 << 20,
  parameter int unsigned CW        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BITLEN-1:0] req_x_bar,
  input  logic [BITLEN-1:0] req_m_bar,
  input  logic [BITLEN-1:0] req_e,
  input  logic [9:0]        req_e_idx,
  input  logic [BITLEN-1:0] req_n,
  input  logic [9:0]        req_mp_count,
  output logic              me_start,
  output logic [BITLEN-1:0] me_e,
  output logic [BITLEN-1:0] me_n,
  output logic [9:0]        me_e_idx,
  output logic [9:0]        me_mp_count,
  input  logic              me_stop,
  input  logic [BITLEN:0]   me_ans,
  output logic              br_wr_en,
  output logic [ABITS-1:0]  br_wr_addr,
  output logic [DBITS-1:0]  br_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BITLEN:0]   rsp_ans,
  output logic              rsp_timeout,
  output logic [CW-1:0]     rsp_cycles,
  output logic              busy
);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [BITLEN-1:0] r_x_bar;
  logic [BITLEN-1:0] r_m_bar;
  logic [BITLEN-1:0] w_x_src;
  logic [DBITS-1:0]  w_wr_data_nxt;
  logic              w_accept;
  logic              w_fin_ok;
  logic              w_fin_to;
  logic              w_tmr_clr;
  logic              w_tmr_en;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_timeout;
  logic              w_stop_rise;

  run_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_tmr_clr),
    .i_enable      (w_tmr_en),
    .i_stop        (me_stop),
    .o_count_nxt_c (w_cnt_nxt),
    .o_timeout_c   (w_timeout),
    .o_stop_rise_c (w_stop_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state; a stop edge takes priority over a same-cycle timeout
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    w_fin_ok    = 1'b0;
    w_fin_to    = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (r_idx == IDX_W'(OPER_WORDS - 1)) begin
          w_state_nxt = ST_START;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      ST_START: begin
        w_tmr_clr   = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_tmr_en = 1'b1;
        if (w_stop_rise) begin
          w_fin_ok    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_timeout) begin
          w_fin_to    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // On the accept edge the base comes straight from the request port
  always_comb begin
    w_x_src       = w_accept ? req_x_bar : r_x_bar;
    w_wr_data_nxt = '0;
    if (w_state_nxt == ST_LOAD) begin
      if (w_idx_nxt == IDX_W'(OFF_X_LO)) begin
        w_wr_data_nxt = DBITS'(w_x_src);
      end else if (w_idx_nxt == IDX_W'(OFF_M_LO)) begin
        w_wr_data_nxt = DBITS'(r_m_bar);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      me_start    <= 1'b0;
      me_e        <= '0;
      me_n        <= '0;
      me_e_idx    <= '0;
      me_mp_count <= '0;
      r_x_bar     <= '0;
      r_m_bar     <= '0;
      br_wr_en    <= 1'b0;
      br_wr_addr  <= '0;
      br_wr_data  <= '0;
      rsp_valid   <= 1'b0;
      rsp_ans     <= '0;
      rsp_timeout <= 1'b0;
      rsp_cycles  <= '0;
    end else begin
      req_ready  <= (w_state_nxt == ST_IDLE);
      busy       <= (w_state_nxt != ST_IDLE);
      me_start   <= (w_state_nxt == ST_START);
      rsp_valid  <= (w_state_nxt == ST_DONE);
      br_wr_en   <= (w_state_nxt == ST_LOAD);
      br_wr_addr <= (w_state_nxt == ST_LOAD) ? ABITS'(BASE_ADDR) + ABITS'(w_idx_nxt) : '0;
      br_wr_data <= w_wr_data_nxt;
      if (w_accept) begin
        me_e        <= req_e;
        me_n        <= req_n;
        me_e_idx    <= req_e_idx;
        me_mp_count <= req_mp_count;
        r_x_bar     <= req_x_bar;
        r_m_bar     <= req_m_bar;
      end
      if (w_fin_ok) begin
        rsp_ans     <= me_ans;
        rsp_timeout <= 1'b0;
        rsp_cycles  <= w_cnt_nxt;
      end else if (w_fin_to) begin
        rsp_ans     <= '0;
        rsp_timeout <= 1'b1;
        rsp_cycles  <= w_cnt_nxt;
      end
    end
  end

endmodule

// File: doc/mon_exp_seq.md
# mon_exp_seq

Request/response sequencer placed in front of `mon_exp` and the `bram` operand store. It accepts one modular-exponentiation job per handshake and writes X_bar and M_bar into the bram's second write port in the 4-word operand layout. It then pulses `start` on `mon_exp`, waits for the rising edge of `stop`, and returns `ans` with a run-cycle count and a timeout flag. It replaces hand-driven operand loading and start sequencing.

## Interface
- `BITLEN`, 512: operand width; matches `mon_exp` bitLen.
- `ABITS`, 8: bram address width.
- `DBITS`, 512: bram data width; `BITLEN` <= `DBITS`.
- `BASE_ADDR`, 0: first bram word of the operand block.
- `TIMEOUT`, 2**20: maximum RUN cycles before the job is abandoned.
- `CW`, 32: cycle-counter width.

Ports:
- `clk`  in  1  clock; all logic is on the posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  job offered.
- `req_ready`  out  1  block is idle and can accept a job.
- `req_x_bar`  in  BITLEN  Montgomery-form base.
- `req_m_bar`  in  BITLEN  Montgomery-form accumulator seed.
- `req_e`  in  BITLEN  exponent.
- `req_e_idx`  in  10  index of the exponent MSB.
- `req_n`  in  BITLEN  modulus.
- `req_mp_count`  in  10  `mon_exp` iteration count.
- `me_start`  out  1  one-cycle start pulse to `mon_exp`.
- `me_e`, `me_n`  out  BITLEN  registered copies of the job fields.
- `me_e_idx`, `me_mp_count`  out  10  registered copies of the job fields.
- `me_stop`  in  1  `mon_exp` done level.
- `me_ans`  in  BITLEN+1  `mon_exp` result.
- `br_wr_en`  out  1  bram WR_EN2.
- `br_wr_addr`  out  ABITS  bram WR_ADDR2.
- `br_wr_data`  out  DBITS  bram WR_DATA2.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_ans`  out  BITLEN+1  captured answer; 0 on timeout.
- `rsp_timeout`  out  1  job exceeded `TIMEOUT`.
- `rsp_cycles`  out  CW  RUN cycles from the `me_start` cycle to `stop` detection.
- `busy`  out  1  state != IDLE.

## Operation
- **States:** IDLE, LOAD, START, RUN, DONE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, register all `req_*` fields and go to LOAD with word index 0.
- **LOAD:** four cycles. Each cycle drives `br_wr_en`=1 and `br_wr_addr`=BASE_ADDR+idx, with data by index:
  - 0: `x_bar` zero-extended to DBITS.
  - 1: 0.
  - 2: `m_bar` zero-extended.
  - 3: 0.
  - After idx 3, go to START.
- **START:**
  - One cycle with `me_start`=1.
  - Clear the cycle counter to 1.
  - Go to RUN.
- **RUN:**
  - The counter increments every cycle and saturates at all-ones.
  - A rising edge of `stop` is detected as `me_stop`=1 while registered `stop_q`=0. On detection, capture `me_ans` into `rsp_ans`, set `rsp_timeout`=0, and go to DONE.
  - `stop_q` updates every cycle in every state, so a `stop` level still high from the previous job is never taken as completion.
- **Timeout:** if the counter reaches `TIMEOUT` in RUN with no edge, set `rsp_ans`=0 and `rsp_timeout`=1, then go to DONE. `mon_exp` is not aborted; the next job is still permitted.
- **Simultaneous stop and timeout:** if a `stop` edge and the timeout occur in the same cycle, the `stop` edge wins.
- **DONE:**
  - `rsp_valid`=1, with `rsp_*` held stable.
  - On `rsp_ready`, go to IDLE.
  - A new request is not accepted in the same cycle.
- **Held outputs:** `me_e`, `me_n`, `me_e_idx` and `me_mp_count` hold their values from the accept cycle until the next accept.
- **Reset (any state, including mid-LOAD or mid-RUN):**
  - State goes to IDLE.
  - All outputs go to 0 except `req_ready`, which goes to 1.
  - `stop_q` goes to 0.
  - A partially written operand block is left as is.

## Timing
- Accept at edge T0.
- `br_wr_en` is high for cycles T0+1 .. T0+4, at addresses BASE+0 .. BASE+3.
- `me_start` is high in cycle T0+5.
- A `stop` rising edge sampled at edge Ts gives `rsp_valid` at Ts+1, with `rsp_cycles` = Ts − (T0+5) + 1.
- The minimum accept-to-`rsp_valid` latency is 7 cycles.
- All outputs are registered; there are no combinational paths from input to output.
- Back-to-back throughput: IDLE is re-entered one cycle after the `rsp` handshake.

## Structure
- Shared package `rsa_pkg`:
  - state enum;
  - operand word offsets `OFF_X_LO`=0, `OFF_X_HI`=1, `OFF_M_LO`=2, `OFF_M_HI`=3;
  - `OPER_WORDS`=4;
  - default `BITLEN`, `ABITS` and `DBITS`.
- One sub-module: `run_timer`. It contains the cycle counter with clear/enable/saturate, a `TIMEOUT` compare and the `stop` edge detector.

## Test plan
- **Basic job.** Stimulus: `x_bar`=435, `m_bar`=571, `e`=300, `e_idx`=8, `n`=589, `mp_count`=10, with a behavioural `mon_exp` stub that raises `stop` 37 cycles after `start` with `ans`=123. Required response:
  - bram writes (0,435), (1,0), (2,571), (3,0) on consecutive cycles;
  - a single `me_start` pulse at T0+5;
  - `rsp_ans`=123, `rsp_cycles`=37, `rsp_timeout`=0.
- **Stale stop level.** Stimulus: the stub holds `stop` high from the previous job and drops it 2 cycles after the new start, then raises it after 20. Required response: `rsp_cycles`=20, not 1.
- **Timeout.** Stimulus: `TIMEOUT`=64 and the stub never raises `stop`. Required response: `rsp_valid` with `rsp_timeout`=1, `rsp_ans`=0, `rsp_cycles`=64. The next job then completes normally.
- **Backpressure.** Stimulus: `rsp_ready` held low for 10 cycles. Required response: `rsp_*` stable, `req_ready`=0 throughout, and a new `req_valid` is ignored until the handshake completes.
- **Reset mid-LOAD and mid-RUN.** Stimulus: assert `rst` after the second write, and again 5 cycles into RUN. Required response:
  - `br_wr_en`, `me_start` and `rsp_valid` go to 0 immediately (asynchronously);
  - `req_ready`=1 after reset is released;
  - a fresh job completes correctly.
- **Non-zero base.** Stimulus: `BASE_ADDR`=8. Required response: writes land at addresses 8..11.
